reg_write_sequencer: RTL
========================

Name:
reg_write_sequencer

Overview:
- Owns the register-file write port. It drives Write_Reg, Write_Data and Reg_Write into the register file, which commits on posedge Clock.
- After reset it runs an init sweep: zeroes $1..$31 and loads $29 (stack pointer) with SP_INIT.
- It then drains writeback requests from the datapath through a small FIFO, one write per cycle, using a valid/ready handshake.
- Writes to $0 are discarded.

Parameters:
- DEPTH, 4: writeback FIFO entries. Power of two, 2..16.
- SP_INIT, 32'h7FFFEFFC: value written to $29 during the init sweep.
- CW, 3: Fifo_Count width, equal to log2(DEPTH)+1.

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- WB_Valid  in  1  writeback request valid.
- WB_Ready  out  1  FIFO can accept a request this cycle.
- WB_Reg  in  5  destination register number.
- WB_Data  in  32  destination data.
- Write_Reg  out  5  register-file write address.
- Write_Data  out  32  register-file write data.
- Reg_Write  out  1  register-file write enable.
- Init_Done  out  1  high once the init sweep has completed.
- Fifo_Count  out  CW  current FIFO occupancy.

Behaviour:
- Reset (sampled at posedge):
  - state=INIT, idx=1, FIFO emptied.
  - Reg_Write=0, Write_Reg=0, Write_Data=0, Init_Done=0, Fifo_Count=0.
  - A reset asserted mid-burst or mid-init discards all queued requests and restarts the sweep.
- All outputs are registered. WB_Ready is combinational: (Fifo_Count < DEPTH) && !reset.
- Push: on a posedge with WB_Valid && WB_Ready, {WB_Reg, WB_Data} is written at the tail.
  - Requests are accepted in any state, including INIT.
  - No push when full, even if a pop happens in the same cycle.
  - WB_Reg/WB_Data are ignored when WB_Valid=0.
- State INIT: each cycle drive Reg_Write=1, Write_Reg=idx, Write_Data=(idx==29 ? SP_INIT : 0), then idx++.
  - After idx=31 is driven: state -> RUN, Init_Done=1 on the next edge.
  - The sweep is exactly 31 cycles; $0 is never written.
  - No FIFO pops occur during INIT.
- State RUN, FIFO non-empty: pop head at posedge and load the output registers in the same edge.
  - Reg_Write=1 unless the head's reg is 0. A $0 entry is popped, but Reg_Write=0 and Write_Reg/Write_Data hold their previous values.
- State RUN, FIFO empty: Reg_Write=0; Write_Reg/Write_Data hold.
- Latency without bypass: request accepted at edge N with FIFO empty is presented (Reg_Write=1) after edge N+1, and the register file commits at edge N+2.
- Simultaneous push and pop: Fifo_Count unchanged. Order is strictly FIFO; no coalescing of same-register writes.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Fifo_Count ranges 0..DEPTH.
- Throughput is 1 write/cycle sustained in RUN.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: in RUN with Fifo_Count==0, an accepted request bypasses the FIFO and loads the output registers at the accept edge N.
  - Reg_Write is visible after edge N, so latency is 1.
  - Fifo_Count stays 0.
  - The $0 drop rule still applies.
  - Bypass is never used in INIT.
- Undefined: every request goes through the FIFO, with the latency given above.

Test Plan:
1. Init sweep: assert reset 2 cycles, release -> exactly 31 cycles of Reg_Write=1 with Write_Reg 1..31.
   - Write_Data=0 except reg 29=32'h7FFFEFFC.
   - Init_Done rises the cycle after Write_Reg=31.
   - A reference register-file model then reads $29=0x7FFFEFFC and $5=0.
2. Single write in RUN: WB_Reg=5, WB_Data=0x12345678, valid 1 cycle -> Reg_Write=1, Write_Reg=5, Write_Data=0x12345678 exactly 1 cycle, appearing after edge N+1.
   - With WB_BYPASS_EN: appears after edge N.
3. Backpressure: hold WB_Valid with 6 requests (regs 1..6, data 0x11..0x66) while in INIT.
   - WB_Ready drops after 4 accepts and Fifo_Count=4.
   - After Init_Done, writes emerge in order 1..6 on consecutive cycles, and each request is written exactly once.
4. Zero register: requests ($0, 0xDEADBEEF), then ($7, 0x7) -> no Reg_Write for $0; Fifo_Count decrements; $7 is written one cycle later.
5. Reset mid-burst: queue 3 requests, assert reset before any drains -> Reg_Write=0 and Fifo_Count=0 after the edge.
   - The sweep restarts at Write_Reg=1, and none of the 3 queued values is ever written.
6. Simultaneous push/pop: in RUN with Fifo_Count=2, push 1 while popping -> Fifo_Count stays 2 and output order is preserved.

Source files
------------

// File: rtl/reg_write_sequencer.sv
// Register-file write-port owner: a 31-cycle init sweep ($1..$31, $29 <- SP_INIT), then FIFO-drained writebacks.
// Build macro WB_BYPASS_EN: in RUN, a request arriving at an empty FIFO skips it (latency 1).
module reg_write_sequencer #(
    parameter int          DEPTH   = 4,
    parameter logic [31:0] SP_INIT = 32'h7FFF_EFFC,
    parameter int          CW      = 3
) (
    input  logic          Clock,
    input  logic          reset,
    input  logic          WB_Valid,
    output logic          WB_Ready,
    input  logic [4:0]    WB_Reg,
    input  logic [31:0]   WB_Data,
    output logic [4:0]    Write_Reg,
    output logic [31:0]   Write_Data,
    output logic          Reg_Write,
    output logic          Init_Done,
    output logic [CW-1:0] Fifo_Count
);
    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [4:0]    SP_REG   = 5'd29;
    localparam logic [4:0]    LAST_REG = 5'd31;

    typedef enum logic {S_INIT, S_RUN} state_t;

    typedef struct packed {
        logic [4:0]  rg;
        logic [31:0] data;
    } wb_req_t;

    state_t        state_q;
    logic [4:0]    idx_q;
    wb_req_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [4:0]    write_reg_q;
    logic [31:0]   write_data_q;
    logic          reg_write_q;
    logic          init_done_q;

    logic    accept;
    logic    pop;
    logic    bypass;
    logic    fifo_push;
    wb_req_t head;

    // NOTE: every signal driven here gets a value on every path (count_d is defaulted first), so no latch is inferred.
    always_comb begin
        WB_Ready  = (count_q < FULL) && !reset;
        accept    = WB_Valid && WB_Ready;
        pop       = (state_q == S_RUN) && (count_q != '0);
`ifdef WB_BYPASS_EN
        bypass    = accept && (state_q == S_RUN) && (count_q == '0);
`else
        bypass    = 1'b0;
`endif
        fifo_push = accept && !bypass;
        head      = mem_q[rd_ptr_q];
        count_d   = count_q;
        if (fifo_push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !fifo_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // NOTE: FIFO storage is deliberately not reset; an entry is only read after it has been written.
    always_ff @(posedge Clock) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q] <= '{rg: WB_Reg, data: WB_Data};
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q      <= S_INIT;
            idx_q        <= 5'd1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            init_done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            reg_write_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    reg_write_q  <= 1'b1;
                    write_reg_q  <= idx_q;
                    write_data_q <= (idx_q == SP_REG) ? SP_INIT : '0;
                    if (idx_q == LAST_REG) begin
                        state_q <= S_RUN;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
                S_RUN: begin
                    init_done_q <= 1'b1;
                    // $0 entries are consumed but leave the write port idle and holding.
                    if (pop) begin
                        if (head.rg != '0) begin
                            reg_write_q  <= 1'b1;
                            write_reg_q  <= head.rg;
                            write_data_q <= head.data;
                        end
                    end else if (bypass && (WB_Reg != '0)) begin
                        reg_write_q  <= 1'b1;
                        write_reg_q  <= WB_Reg;
                        write_data_q <= WB_Data;
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign Write_Reg  = write_reg_q;
    assign Write_Data = write_data_q;
    assign Reg_Write  = reg_write_q;
    assign Init_Done  = init_done_q;
    assign Fifo_Count = count_q;

endmodule
